// File: rtl/mc_ctrl_fsm_if.sv
// Memory handshake bundle between the multicycle sequencer and the shared memory port.
// The controller holds a request level-stable until the memory returns mem_ready.
interface mc_ctrl_fsm_if;
    logic mem_req;
    logic MemWrite;
    logic AdrSrc;
    logic mem_ready;

    modport master (output mem_req, MemWrite, AdrSrc, input mem_ready);
    modport slave  (input mem_req, MemWrite, AdrSrc, output mem_ready);
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Multicycle RV32I control sequencer: Fetch/Decode/Execute/Memory/Writeback walk.
// Optional feature macro ILLEGAL_TRAP_EN: unknown opcodes trap instead of acting as NOPs.
module mc_ctrl_fsm #(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic                 clk,
    input  logic                 reset,
    mc_ctrl_fsm_if.master        mem,
    input  logic [6:0]           op,
    input  logic [2:0]           funct3,
    input  logic                 funct7b5,
    input  logic                 Zero,
    output logic                 IRWrite,
    output logic                 PCWrite,
    output logic                 RegWrite,
    output logic [1:0]           ResultSrc,
    output logic [1:0]           ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ImmSrc,
    output logic [2:0]           ALUControl,
    output logic                 retire,
    output logic                 illegal_instr
);

    localparam int unsigned OP_W = 7;

    localparam logic [OP_W-1:0] OP_LW  = 7'b0000011;
    localparam logic [OP_W-1:0] OP_SW  = 7'b0100011;
    localparam logic [OP_W-1:0] OP_R   = 7'b0110011;
    localparam logic [OP_W-1:0] OP_I   = 7'b0010011;
    localparam logic [OP_W-1:0] OP_BEQ = 7'b1100011;
    localparam logic [OP_W-1:0] OP_JAL = 7'b1101111;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10
`ifdef ILLEGAL_TRAP_EN
        , TRAP   = 4'd11
`endif
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [1:0] alu_op;
    logic       mem_req_c;
    logic       mem_write_c;
    logic       adr_src_c;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= state_t'(RESET_STATE);
        else       state_q <= state_d;
    end

    // Next state and Moore decodes; memory/zero gating applied inline
    always_comb begin
        state_d     = state_q;
        mem_req_c   = 1'b0;
        mem_write_c = 1'b0;
        adr_src_c   = 1'b0;
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        RegWrite    = 1'b0;
        ResultSrc   = 2'b00;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        alu_op      = ALU_ADD;
        retire      = 1'b0;

        case (state_q)
            FETCH: begin
                mem_req_c = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = mem.mem_ready;
                PCWrite   = mem.mem_ready;
                if (mem.mem_ready) state_d = DECODE;
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_R:         state_d = EXECR;
                    OP_I:         state_d = EXECI;
                    OP_BEQ:       state_d = BEQ;
                    OP_JAL:       state_d = JAL;
                    default: begin
`ifdef ILLEGAL_TRAP_EN
                        state_d = TRAP;
`else
                        state_d = FETCH;
                        retire  = 1'b1;
`endif
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = op[5] ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                mem_req_c = 1'b1;
                adr_src_c = 1'b1;
                if (mem.mem_ready) state_d = MEMWB;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
                retire    = 1'b1;
                state_d   = FETCH;
            end
            MEMWRITE: begin
                mem_req_c   = 1'b1;
                mem_write_c = 1'b1;
                adr_src_c   = 1'b1;
                retire      = mem.mem_ready;
                if (mem.mem_ready) state_d = FETCH;
            end
            EXECR: begin
                ALUSrcA = 2'b10;
                alu_op  = ALU_FUNCT;
                state_d = ALUWB;
            end
            EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                alu_op  = ALU_FUNCT;
                state_d = ALUWB;
            end
            ALUWB: begin
                RegWrite = 1'b1;
                retire   = 1'b1;
                state_d  = FETCH;
            end
            BEQ: begin
                ALUSrcA = 2'b10;
                alu_op  = ALU_SUB;
                PCWrite = Zero;
                retire  = 1'b1;
                state_d = FETCH;
            end
            JAL: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
                state_d = ALUWB;
            end
`ifdef ILLEGAL_TRAP_EN
            TRAP: state_d = TRAP;
`endif
            default: state_d = FETCH;
        endcase

        // Reset abandons any access and suppresses every side effect
        if (reset) begin
            mem_req_c   = 1'b0;
            mem_write_c = 1'b0;
            IRWrite     = 1'b0;
            PCWrite     = 1'b0;
            RegWrite    = 1'b0;
            retire      = 1'b0;
        end
    end

    assign mem.mem_req  = mem_req_c;
    assign mem.MemWrite = mem_write_c;
    assign mem.AdrSrc   = adr_src_c;

    // ALU operation decode
    always_comb begin
        ALUControl = 3'b000;
        case (alu_op)
            ALU_SUB: ALUControl = 3'b001;
            ALU_FUNCT: begin
                case (funct3)
                    3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  ALUControl = 3'b101;
                    3'b110:  ALUControl = 3'b011;
                    3'b111:  ALUControl = 3'b010;
                    default: ALUControl = 3'b000;
                endcase
            end
            default: ALUControl = 3'b000;
        endcase
    end

    // Immediate format straight from the opcode
    always_comb begin
        case (op)
            OP_SW:   ImmSrc = 2'b01;
            OP_BEQ:  ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

`ifdef ILLEGAL_TRAP_EN
    logic illegal_q;

    // Sticky from TRAP entry until reset
    always_ff @(posedge clk) begin
        if (reset)                illegal_q <= 1'b0;
        else if (state_d == TRAP) illegal_q <= 1'b1;
    end

    assign illegal_instr = illegal_q;
`else
    assign illegal_instr = 1'b0;
`endif

endmodule
